// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte UART among NUM_REQ packet streams, locked per packet.
// Grant-to-en is 2 cycles and done-to-next-en is 2 cycles; requesters are held off by withholding req_ready, and stalled packets are aborted on timeout.
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] DONE_TIMEOUT = 16'd4096,
  parameter logic [15:0] HOLD_TIMEOUT = 16'd25000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_en,
  input  logic                   uart_tx_done,
  output logic [2:0]             grant,
  output logic                   busy,
  output logic                   pkt_abort
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         rr_q, rr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               en_q, en_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               abort;

  logic               g_valid, g_last;
  logic [7:0]         g_data;
  logic [NUM_REQ-1:0] g_onehot;
  logic               pick_vld;
  logic [2:0]         pick_idx;
  logic [2:0]         next_ptr;

  // View of the currently granted lane.
  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = 8'd0;
    g_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid     = req_valid[i];
        g_last      = req_last[i];
        g_data      = req_data[8*i +: 8];
        g_onehot[i] = 1'b1;
      end
    end
  end

  // Lower rotation distance overwrites later, so the first valid lane from rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (((int'(rr_q) + k) % NUM_REQ) == i)) begin
          pick_vld = 1'b1;
          pick_idx = 3'(i);
        end
      end
    end
  end

  assign next_ptr = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    en_d    = 1'b0;
    ready_d = '0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        data_d  = g_data;
        last_d  = g_last;
        en_d    = 1'b1;
        ready_d = g_onehot & req_valid;
        cnt_d   = 16'd0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done arriving on the timeout cycle takes priority over the abort.
        if (uart_tx_done) begin
          cnt_d = 16'd0;
          if (last_q) begin
            rr_d    = next_ptr;
            state_d = ST_IDLE;
          end else if (g_valid) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (cnt_q == DONE_TIMEOUT) begin
          abort   = 1'b1;
          rr_d    = next_ptr;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (g_valid) begin
          state_d = ST_SEND;
        end else if (cnt_q == HOLD_TIMEOUT) begin
          abort   = 1'b1;
          rr_d    = next_ptr;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 3'd0;
      rr_q    <= 3'd0;
      cnt_q   <= 16'd0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      en_q    <= en_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready    = ready_q;
  assign uart_tx_data = data_q;
  assign uart_tx_en   = en_q;
  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign pkt_abort    = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters, shortened timeouts, hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_en;
  logic          uart_tx_done;
  logic [2:0]    grant;
  logic          busy;
  logic          pkt_abort;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DONE_TIMEOUT(16'd100),
    .HOLD_TIMEOUT(16'd80)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_tx_data(uart_tx_data),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_done(uart_tx_done),
    .grant       (grant),
    .busy        (busy),
    .pkt_abort   (pkt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic v, input logic [7:0] d, input logic l);
    req_valid[lane]       = v;
    req_data[8*lane +: 8] = d;
    req_last[lane]        = l;
  endtask

  // Waits (bounded) for uart_tx_en and checks latency, byte, ready lane and grant.
  task automatic expect_en(input string tag, input int lane, input logic [7:0] exp, input int lat);
    int n;
    n = 0;
    while (uart_tx_en !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " data"}, uart_tx_data, exp);
    chk({tag, " ready"}, req_ready, 32'd1 << lane);
    chk({tag, " grant"}, grant, lane);
  endtask

  // uart_tx_done is sampled on the d-th rising edge from now.
  task automatic pulse_done(input int d);
    repeat (d - 1) step();
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
  endtask

  initial begin
    int   n;
    logic bad;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_done = 1'b0;
    step();
    step();
    chk("rst en", uart_tx_en, 0);
    chk("rst ready", req_ready, 0);
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    chk("rst abort", pkt_abort, 0);
    chk("rst data", uart_tx_data, 0);
    rst_n = 1'b1;
    step();

    // Single three-byte packet on lane 2, done 10 cycles after each en.
    set_lane(2, 1'b1, 8'hA1, 1'b0);
    expect_en("pkt b0", 2, 8'hA1, 2);
    chk("pkt busy", busy, 1);
    set_lane(2, 1'b1, 8'hA2, 1'b0);
    pulse_done(10);
    expect_en("pkt b1", 2, 8'hA2, 1);
    set_lane(2, 1'b1, 8'hA3, 1'b1);
    pulse_done(10);
    expect_en("pkt b2", 2, 8'hA3, 1);
    set_lane(2, 1'b0, 8'h00, 1'b0);
    pulse_done(10);
    chk("pkt idle", busy, 0);
    // rr_ptr is now 3: lane 3 beats lane 0, then lane 0 follows.
    set_lane(0, 1'b1, 8'h55, 1'b1);
    set_lane(3, 1'b1, 8'h33, 1'b1);
    expect_en("rr3", 3, 8'h33, 2);
    set_lane(3, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    expect_en("rr0", 0, 8'h55, 2);
    set_lane(0, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    chk("rr idle", busy, 0);

    // Contention from reset: lanes 0 and 1, then a new lane 0 packet after lane 1.
    rst_n = 1'b0;
    set_lane(0, 1'b1, 8'h10, 1'b1);
    set_lane(1, 1'b1, 8'h20, 1'b1);
    step();
    chk("cont rst busy", busy, 0);
    rst_n = 1'b1;
    expect_en("cont r0", 0, 8'h10, 2);
    set_lane(0, 1'b0, 8'h00, 1'b0);
    pulse_done(5);
    expect_en("cont r1", 1, 8'h20, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    set_lane(0, 1'b1, 8'h11, 1'b1);
    pulse_done(5);
    expect_en("cont r0b", 0, 8'h11, 2);
    set_lane(0, 1'b0, 8'h00, 1'b0);
    pulse_done(5);

    // Lock: lane 1 stalls 50 cycles mid-packet while lane 3 waits.
    set_lane(1, 1'b1, 8'h41, 1'b0);
    set_lane(3, 1'b1, 8'h77, 1'b1);
    expect_en("lock b0", 1, 8'h41, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    pulse_done(4);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready[3] !== 1'b0 || uart_tx_en !== 1'b0) bad = 1'b1;
      step();
    end
    chk("lock no serve", bad, 0);
    chk("lock grant", grant, 1);
    chk("lock busy", busy, 1);
    chk("lock abort", pkt_abort, 0);
    set_lane(1, 1'b1, 8'h42, 1'b1);
    expect_en("lock b1", 1, 8'h42, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    pulse_done(4);
    expect_en("lock r3", 3, 8'h77, 2);
    set_lane(3, 1'b0, 8'h00, 1'b0);
    pulse_done(4);

    // Done timeout: done never returns for lane 0, lane 2 is served next.
    set_lane(0, 1'b1, 8'h90, 1'b0);
    set_lane(2, 1'b1, 8'hB0, 1'b1);
    expect_en("dto b0", 0, 8'h90, 2);
    set_lane(0, 1'b1, 8'h91, 1'b1);
    n = 0;
    while (pkt_abort !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("dto cycles", n, 100);
    chk("dto busy", busy, 1);
    expect_en("dto next", 2, 8'hB0, 3);
    set_lane(2, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    expect_en("dto r0", 0, 8'h91, 2);
    set_lane(0, 1'b0, 8'h00, 1'b0);
    pulse_done(3);

    // Hold timeout: valid on the timeout cycle wins; one cycle late aborts.
    set_lane(1, 1'b1, 8'hC1, 1'b0);
    expect_en("hto b0", 1, 8'hC1, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    repeat (80) step();
    set_lane(1, 1'b1, 8'hC2, 1'b0);
    #1;
    chk("hto coinc abort", pkt_abort, 0);
    expect_en("hto b1", 1, 8'hC2, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    repeat (80) step();
    chk("hto abort", pkt_abort, 1);
    chk("hto abort grant", grant, 1);
    step();
    set_lane(1, 1'b1, 8'hC3, 1'b1);
    chk("hto idle first", busy, 0);
    chk("hto abort end", pkt_abort, 0);
    expect_en("hto new", 1, 8'hC3, 2);
    set_lane(1, 1'b0, 8'h00, 1'b0);
    pulse_done(3);

    // Reset during WAIT_DONE, late done ignored, lane 0 first after release.
    set_lane(2, 1'b1, 8'hD1, 1'b0);
    set_lane(0, 1'b1, 8'hD0, 1'b1);
    expect_en("mrst b0", 2, 8'hD1, 2);
    set_lane(2, 1'b1, 8'hD2, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst en", uart_tx_en, 0);
    chk("mrst ready", req_ready, 0);
    chk("mrst busy", busy, 0);
    chk("mrst grant", grant, 0);
    chk("mrst data", uart_tx_data, 0);
    chk("mrst abort", pkt_abort, 0);
    step();
    rst_n        = 1'b1;
    uart_tx_done = 1'b1;
    step();
    uart_tx_done = 1'b0;
    chk("mrst after grant", grant, 0);
    expect_en("mrst r0", 0, 8'hD0, 1);
    set_lane(0, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    expect_en("mrst r2", 2, 8'hD2, 2);
    set_lane(2, 1'b0, 8'h00, 1'b0);
    pulse_done(3);
    chk("mrst end idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
